eco32f_registerfile_mp: RTL and testbench
=========================================

# eco32f_registerfile_mp

Parametrised multi-read-port register file for the eco32f pipeline, sitting between decode (ID) and execute (EX) with write-back from WB. It generalises data width, register count and read-port count, forwards EX/MEM results into EX operands, flags load-use hazards for long-latency (late) results, and optionally zero-clears its storage after reset via a sequencer.

## Interface
- DATA_WIDTH, 32, register width
- ADDR_WIDTH, 5, register address width; 2**ADDR_WIDTH registers
- NUM_RD, 2, number of read ports; port k occupies slice [k*ADDR_WIDTH +: ADDR_WIDTH] / [k*DATA_WIDTH +: DATA_WIDTH]

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- id_stall  in  1  hold ID-stage read and bypass flags
- ex_stall  in  1  hold EX->MEM destination registers
- ex_flush  in  1  kill EX instruction's write
- id_rd_addr  in  NUM_RD*ADDR_WIDTH  ID read addresses
- ex_rd_addr  in  NUM_RD*ADDR_WIDTH  EX copies of read addresses
- ex_rf_r_addr  in  ADDR_WIDTH  EX destination
- ex_rf_r_we  in  1  EX writes a register
- ex_rf_r_late  in  1  EX result available only in WB (load)
- mem_rf_r_addr  out  ADDR_WIDTH  MEM destination
- mem_rf_r_we  out  1  MEM writes a register
- mem_rf_r_late  out  1  MEM result is late
- mem_alu_result  in  DATA_WIDTH  MEM-stage result
- ex_rd_data  out  NUM_RD*DATA_WIDTH  EX operands
- wb_rf_r_addr  in  ADDR_WIDTH  WB destination
- wb_rf_r_we  in  1  WB write enable
- wb_rf_r  in  DATA_WIDTH  WB data
- id_hazard  out  1  load-use hazard; pipeline must stall ID
- rf_ready  out  1  storage usable

## Operation
- Storage: one simple dual-port RAM per read port, shared write port, internal write-before-read bypass (same-cycle write/read of one address returns new data). Read enable = !id_stall & rf_ready.
- MEM regs: when !ex_stall load ex_rf_r_addr/we/late; ex_flush forces mem_rf_r_we=0 (priority over stall).
- Bypass flags per port k, registered when !id_stall: ex_byp[k] = ex_rf_r_we & !ex_rf_r_late & (ex_rf_r_addr==id addr k); mem_byp[k] = mem_rf_r_we & (mem_rf_r_addr==id addr k).
- Operand k: ex addr k==0 -> 0; else ex_byp -> mem_alu_result; else mem_byp -> wb_rf_r; else RAM. EX priority over MEM.
- id_hazard = rf_ready & ex_rf_r_we & ex_rf_r_late & OR over k of (id addr k==ex_rf_r_addr & id addr k!=0). Combinational.
- Sequencer states CLEAR, RUN. CLEAR: write port driven with counter address, data 0, we=1; WB writes ignored; counter increments each cycle; at 2**ADDR_WIDTH-1 go RUN. RUN: write port = WB inputs.

## Timing
- Reset values: mem_rf_r_addr=0, mem_rf_r_we=0, mem_rf_r_late=0, all bypass flags 0, counter 0, state CLEAR (RUN without macro), rf_ready=0 (1 without macro).
- ID->EX read latency 1 cycle; bypass flags aligned with RAM output.
- Clear takes 2**ADDR_WIDTH cycles; rf_ready rises on the following edge.
- Reset asserted mid-clear or mid-run restarts sequencer at address 0.
- Stalled ID: RAM outputs and flags hold; after a load-use stall the load sits in MEM so mem_byp selects wb_rf_r.

## Configuration
- ECO32F_RF_RESET_CLEAR_EN defined: CLEAR state compiled in; all registers read 0 after rf_ready.
- Undefined: sequencer removed, state fixed RUN, rf_ready=1 from reset, RAM contents undefined until written.

## Test plan
- Macro defined, release reset -> rf_ready low 32 cycles, high after; every register on every port reads 0.
- WB writes r5=0xDEADBEEF, ID reads r5 on port 0 same cycle -> next cycle port 0 = 0xDEADBEEF.
- EX writes r3, MEM writes r3, ID reads r3 on port 1, mem_alu_result=0x1234 -> port 1 = 0x1234 (EX priority); EX idle, MEM r3, wb_rf_r=0x5678 -> 0x5678.
- EX late write r9, ID reads r9 -> id_hazard=1; stall one cycle, load in MEM, wb_rf_r=0xCAFE0000 -> operand 0xCAFE0000.
- WB writes r0=0xFFFFFFFF, EX targets r0 with mem_alu_result=0x1 -> r0 reads 0 on all ports; id_hazard=0 for late r0.
- ex_flush with ex_rf_r_we=1 -> mem_rf_r_we=0 next cycle; ex_stall holds mem regs; rst low mid-clear -> counter restarts, rf_ready stays 0.

Source files
------------

// File: rtl/eco32f_registerfile_mp.sv
// rtl/eco32f_registerfile_mp.sv - eco32f multi-read-port register file with EX/MEM bypass and load-use detect
// Post-reset zero-clear sequencer compiled in with ECO32F_RF_RESET_CLEAR_EN
module eco32f_registerfile_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         id_stall,
  input  logic                         ex_stall,
  input  logic                         ex_flush,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] id_rd_addr,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] ex_rd_addr,
  input  logic [ADDR_WIDTH-1:0]        ex_rf_r_addr,
  input  logic                         ex_rf_r_we,
  input  logic                         ex_rf_r_late,
  output logic [ADDR_WIDTH-1:0]        mem_rf_r_addr,
  output logic                         mem_rf_r_we,
  output logic                         mem_rf_r_late,
  input  logic [DATA_WIDTH-1:0]        mem_alu_result,
  output logic [NUM_RD*DATA_WIDTH-1:0] ex_rd_data,
  input  logic [ADDR_WIDTH-1:0]        wb_rf_r_addr,
  input  logic                         wb_rf_r_we,
  input  logic [DATA_WIDTH-1:0]        wb_rf_r,
  output logic                         id_hazard,
  output logic                         rf_ready
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_we;
  logic                  rd_en;
  logic [NUM_RD-1:0]     hz_hit;

`ifdef ECO32F_RF_RESET_CLEAR_EN
  typedef enum logic {CLEAR, RUN} state_t;
  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // While clearing, the write port belongs to the sequencer and WB is ignored
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_addr   = wb_rf_r_addr;
    wr_data   = wb_rf_r;
    wr_we     = wb_rf_r_we;
    rf_ready  = 1'b0;
    case (state)
      CLEAR: begin
        wr_addr = cnt;
        wr_data = '0;
        wr_we   = 1'b1;
        cnt_nxt = cnt + 1'b1;
        if (cnt == {ADDR_WIDTH{1'b1}}) state_nxt = RUN;
      end
      default: rf_ready = 1'b1;
    endcase
  end
`else
  always_comb begin
    wr_addr  = wb_rf_r_addr;
    wr_data  = wb_rf_r;
    wr_we    = wb_rf_r_we;
    rf_ready = 1'b1;
  end
`endif

  assign rd_en = !id_stall && rf_ready;

  // Flush wins over stall so a killed instruction never reaches MEM as a writer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_rf_r_addr <= '0;
      mem_rf_r_we   <= 1'b0;
      mem_rf_r_late <= 1'b0;
    end else begin
      if (!ex_stall) begin
        mem_rf_r_addr <= ex_rf_r_addr;
        mem_rf_r_late <= ex_rf_r_late;
      end
      if (ex_flush)       mem_rf_r_we <= 1'b0;
      else if (!ex_stall) mem_rf_r_we <= ex_rf_r_we;
    end
  end

  genvar k;
  generate
    for (k = 0; k < NUM_RD; k++) begin : g_port
      logic [DATA_WIDTH-1:0] ram [0:NUM_REGS-1];
      logic [DATA_WIDTH-1:0] ram_q;
      logic                  ex_byp;
      logic                  mem_byp;
      logic [ADDR_WIDTH-1:0] id_a;
      logic [ADDR_WIDTH-1:0] ex_a;

      assign id_a = id_rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      assign ex_a = ex_rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

      always_ff @(posedge clk) begin
        if (wr_we) ram[wr_addr] <= wr_data;
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          ram_q   <= '0;
          ex_byp  <= 1'b0;
          mem_byp <= 1'b0;
        end else begin
          if (rd_en)
            ram_q <= (wr_we && wr_addr == id_a) ? wr_data : ram[id_a];
          if (!id_stall) begin
            ex_byp  <= ex_rf_r_we && !ex_rf_r_late && (ex_rf_r_addr == id_a);
            mem_byp <= mem_rf_r_we && (mem_rf_r_addr == id_a);
          end
        end
      end

      assign ex_rd_data[k*DATA_WIDTH +: DATA_WIDTH] =
        (ex_a == '0) ? '0 :
        ex_byp       ? mem_alu_result :
        mem_byp      ? wb_rf_r :
                       ram_q;

      assign hz_hit[k] = (id_a == ex_rf_r_addr) && (id_a != '0);
    end
  endgenerate

  assign id_hazard = rf_ready && ex_rf_r_we && ex_rf_r_late && (|hz_hit);

endmodule

// File: tb/tb_eco32f_registerfile_mp.sv
// tb/tb_eco32f_registerfile_mp.sv - directed self-checking bench for eco32f_registerfile_mp
// Expectations follow ECO32F_RF_RESET_CLEAR_EN when it is defined for the build
module tb_eco32f_registerfile_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           id_stall, ex_stall, ex_flush;
  logic [NR*AW-1:0] id_rd_addr, ex_rd_addr;
  logic [AW-1:0]  ex_rf_r_addr, mem_rf_r_addr, wb_rf_r_addr;
  logic           ex_rf_r_we, ex_rf_r_late, mem_rf_r_we, mem_rf_r_late;
  logic [DW-1:0]  mem_alu_result, wb_rf_r;
  logic [NR*DW-1:0] ex_rd_data;
  logic           wb_rf_r_we, id_hazard, rf_ready;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  eco32f_registerfile_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR)) dut (
    .clk(clk), .rst(rst), .id_stall(id_stall), .ex_stall(ex_stall), .ex_flush(ex_flush),
    .id_rd_addr(id_rd_addr), .ex_rd_addr(ex_rd_addr),
    .ex_rf_r_addr(ex_rf_r_addr), .ex_rf_r_we(ex_rf_r_we), .ex_rf_r_late(ex_rf_r_late),
    .mem_rf_r_addr(mem_rf_r_addr), .mem_rf_r_we(mem_rf_r_we), .mem_rf_r_late(mem_rf_r_late),
    .mem_alu_result(mem_alu_result), .ex_rd_data(ex_rd_data),
    .wb_rf_r_addr(wb_rf_r_addr), .wb_rf_r_we(wb_rf_r_we), .wb_rf_r(wb_rf_r),
    .id_hazard(id_hazard), .rf_ready(rf_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input int k, input logic [AW-1:0] a);
    id_rd_addr[k*AW +: AW] = a;
  endtask

  task automatic set_ex(input int k, input logic [AW-1:0] a);
    ex_rd_addr[k*AW +: AW] = a;
  endtask

  function automatic logic [31:0] port(input int k);
    return ex_rd_data[k*DW +: DW];
  endfunction

  initial begin
    rst = 1'b0; id_stall = 1'b0; ex_stall = 1'b0; ex_flush = 1'b0;
    id_rd_addr = '0; ex_rd_addr = '0;
    ex_rf_r_addr = '0; ex_rf_r_we = 1'b0; ex_rf_r_late = 1'b0;
    mem_alu_result = '0; wb_rf_r_addr = '0; wb_rf_r_we = 1'b0; wb_rf_r = '0;
    #2;
    check("rst_mem_we", 32'(mem_rf_r_we), 32'd0);
    check("rst_mem_addr", 32'(mem_rf_r_addr), 32'd0);
    check("rst_mem_late", 32'(mem_rf_r_late), 32'd0);
`ifdef ECO32F_RF_RESET_CLEAR_EN
    check("rst_ready", 32'(rf_ready), 32'd0);
`else
    check("rst_ready", 32'(rf_ready), 32'd1);
`endif
    tick; tick;
    rst = 1'b1;

`ifdef ECO32F_RF_RESET_CLEAR_EN
    repeat (10) tick;
    check("ready_mid_clear", 32'(rf_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("ready_in_reset", 32'(rf_ready), 32'd0);
    tick;
    rst = 1'b1;
    n = 0;
    while (!rf_ready && n < 100) begin
      tick;
      n++;
    end
    check("clear_cycles", 32'(n), 32'd32);
    for (int a = 0; a < 32; a++) begin
      set_id(0, 5'(a)); set_id(1, 5'(a));
      tick;
      set_ex(0, 5'(a)); set_ex(1, 5'(a));
      #1;
      check($sformatf("clear_p0_r%0d", a), port(0), 32'd0);
      check($sformatf("clear_p1_r%0d", a), port(1), 32'd0);
    end
`else
    tick;
    check("ready_run", 32'(rf_ready), 32'd1);
`endif

    // WB write and ID read of r5 in the same cycle
    wb_rf_r_we = 1'b1; wb_rf_r_addr = 5'd5; wb_rf_r = 32'hDEADBEEF;
    set_id(0, 5'd5);
    tick;
    wb_rf_r_we = 1'b0;
    set_ex(0, 5'd5);
    #1;
    check("wb_same_cycle_p0", port(0), 32'hDEADBEEF);
    id_stall = 1'b1; set_id(0, 5'd0);
    tick;
    check("id_stall_hold_p0", port(0), 32'hDEADBEEF);
    id_stall = 1'b0;

    wb_rf_r_we = 1'b1; wb_rf_r_addr = 5'd6; wb_rf_r = 32'hA5A5A5A5;
    tick;
    wb_rf_r_we = 1'b0;
    set_id(0, 5'd5); set_id(1, 5'd6);
    tick;
    set_ex(0, 5'd5); set_ex(1, 5'd6);
    #1;
    check("ram_read_p0_r5", port(0), 32'hDEADBEEF);
    check("ram_read_p1_r6", port(1), 32'hA5A5A5A5);

    // EX and MEM both target r3: EX wins; then MEM only
    ex_rf_r_we = 1'b1; ex_rf_r_addr = 5'd3;
    tick;
    set_id(1, 5'd3);
    tick;
    check("mem_addr_r3", 32'(mem_rf_r_addr), 32'd3);
    check("mem_we_r3", 32'(mem_rf_r_we), 32'd1);
    ex_rf_r_we = 1'b0;
    set_ex(1, 5'd3); mem_alu_result = 32'h1234; wb_rf_r = 32'h5678;
    #1;
    check("ex_byp_priority_p1", port(1), 32'h1234);
    tick;
    check("mem_byp_p1", port(1), 32'h5678);

    // Load-use on r9
    set_id(0, 5'd9); set_id(1, 5'd4);
    ex_rf_r_we = 1'b1; ex_rf_r_addr = 5'd9; ex_rf_r_late = 1'b1;
    #1;
    check("hazard_p0", 32'(id_hazard), 32'd1);
    set_id(0, 5'd4);
    #1;
    check("hazard_none", 32'(id_hazard), 32'd0);
    set_id(1, 5'd9);
    #1;
    check("hazard_p1", 32'(id_hazard), 32'd1);
    set_id(0, 5'd9); set_id(1, 5'd4);
    id_stall = 1'b1;
    tick;
    id_stall = 1'b0; ex_rf_r_we = 1'b0; ex_rf_r_late = 1'b0;
    #1;
    check("hazard_cleared", 32'(id_hazard), 32'd0);
    check("load_in_mem_late", 32'(mem_rf_r_late), 32'd1);
    tick;
    set_ex(0, 5'd9); wb_rf_r = 32'hCAFE0000; mem_alu_result = 32'h1111;
    #1;
    check("load_use_p0", port(0), 32'hCAFE0000);

    // r0 stays zero on every port
    wb_rf_r_we = 1'b1; wb_rf_r_addr = 5'd0; wb_rf_r = 32'hFFFFFFFF;
    tick;
    wb_rf_r_we = 1'b0;
    set_id(0, 5'd0); set_id(1, 5'd0);
    ex_rf_r_we = 1'b1; ex_rf_r_addr = 5'd0;
    tick;
    set_ex(0, 5'd0); set_ex(1, 5'd0); mem_alu_result = 32'h1;
    #1;
    check("r0_p0", port(0), 32'd0);
    check("r0_p1", port(1), 32'd0);
    ex_rf_r_late = 1'b1;
    #1;
    check("hazard_r0", 32'(id_hazard), 32'd0);
    ex_rf_r_late = 1'b0;

    // Flush and stall of the EX->MEM registers
    ex_rf_r_we = 1'b1; ex_rf_r_addr = 5'd7; ex_flush = 1'b1;
    tick;
    check("flush_we", 32'(mem_rf_r_we), 32'd0);
    ex_flush = 1'b0; ex_rf_r_late = 1'b1;
    tick;
    check("load_we", 32'(mem_rf_r_we), 32'd1);
    check("load_addr", 32'(mem_rf_r_addr), 32'd7);
    ex_stall = 1'b1; ex_rf_r_we = 1'b0; ex_rf_r_addr = 5'd2; ex_rf_r_late = 1'b0;
    tick;
    check("stall_we", 32'(mem_rf_r_we), 32'd1);
    check("stall_addr", 32'(mem_rf_r_addr), 32'd7);
    check("stall_late", 32'(mem_rf_r_late), 32'd1);
    ex_flush = 1'b1;
    tick;
    check("flush_over_stall", 32'(mem_rf_r_we), 32'd0);
    ex_flush = 1'b0; ex_stall = 1'b0;
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
